// File: rtl/mp3_stage_sched.sv
// mp3_stage_sched
//   Schedules the per-granule/channel decode units of one MP3 frame across
//   stage 1 (Huffman/requantizer/stereo) and stage 2 (IMDCT/synthesis MAC).
//   The stages are pipelined through a ping-pong spectral buffer. Stage 1
//   decodes unit k+1 while stage 2 processes unit k.
//
//   Unit order is gr0ch0, gr0ch1, gr1ch0, gr1ch1 for stereo, and gr0, gr1 for
//   mono (ch is always 0 in mono).
//
// Parameters
//   WDOG_W      watchdog counter width. It is used only when the watchdog is
//               built in. The timeout is 2**WDOG_W-1 cycles.
//
// Optional feature
//   MP3_SCHED_WDOG_EN   When defined, a watchdog covers the stage wait
//                       states. Expiry sets the sticky err flag and returns
//                       every FSM to idle.
//
// Ports
//   CLK_I, RST_I           clock; asynchronous active-high reset
//   module_en              enables new unit launches
//   frame_valid, stereo    frame request (level); channel mode, latched when
//                          the frame is accepted
//   frame_ack              one-cycle pulse when all units of the frame are done
//   huff_start/gr/ch/buf   stage-1 launch pulse and unit descriptor
//   huff_done              stage-1 status (1 = idle/done)
//   mac_start/gr/ch/buf    stage-2 launch pulse and unit descriptor
//   mac_done               stage-2 status (1 = idle/done)
//   pcm_free               PCM RAM can accept one more unit
//   busy                   frame in progress
//   err                    sticky watchdog error (0 when no watchdog)
module mp3_stage_sched #(
  parameter int unsigned WDOG_W = 20
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic module_en,
  input  logic frame_valid,
  input  logic stereo,
  output logic frame_ack,
  output logic huff_start,
  input  logic huff_done,
  output logic huff_gr,
  output logic huff_ch,
  output logic huff_buf,
  output logic mac_start,
  input  logic mac_done,
  output logic mac_gr,
  output logic mac_ch,
  output logic mac_buf,
  input  logic pcm_free,
  output logic busy,
  output logic err
);

  if (WDOG_W < 2) begin : g_wdog_w_chk
    $error("mp3_stage_sched: WDOG_W must be at least 2");
  end

  typedef enum logic [1:0] {F_IDLE, F_RUN, F_ACK} f_state_e;
  typedef enum logic [1:0] {H_IDLE, H_START, H_WAIT_BUSY, H_WAIT_DONE} h_state_e;
  typedef enum logic [1:0] {M_IDLE, M_START, M_WAIT_BUSY, M_WAIT_DONE} m_state_e;

  f_state_e   f_state_q, f_state_d;
  h_state_e   h_state_q, h_state_d;
  m_state_e   m_state_q, m_state_d;
  logic       stereo_q, stereo_d;
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [2:0] h_cnt_q, h_cnt_d;
  logic [2:0] m_cnt_q, m_cnt_d;
  logic       huff_gr_q, huff_gr_d, huff_ch_q, huff_ch_d, huff_buf_q, huff_buf_d;
  logic       mac_gr_q, mac_gr_d, mac_ch_q, mac_ch_d, mac_buf_q, mac_buf_d;

  logic       wd_abort;
  logic       err_s;

  logic [2:0] units;
  logic       frame_run;
  logic       h_launch, m_launch;
  logic       h_cmpl, m_cmpl;

  assign units     = stereo_q ? 3'd4 : 3'd2;
  assign frame_run = (f_state_q == F_RUN);
  assign h_launch  = frame_run & module_en & (h_cnt_q < units) & ~full_q[wr_ptr_q];
  assign m_launch  = frame_run & module_en & (m_cnt_q < h_cnt_q) & full_q[rd_ptr_q] & pcm_free;
  assign h_cmpl    = (h_state_q == H_WAIT_DONE) & huff_done;
  assign m_cmpl    = (m_state_q == M_WAIT_DONE) & mac_done;

  always_comb begin
    f_state_d  = f_state_q;
    h_state_d  = h_state_q;
    m_state_d  = m_state_q;
    stereo_d   = stereo_q;
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    h_cnt_d    = h_cnt_q;
    m_cnt_d    = m_cnt_q;
    huff_gr_d  = huff_gr_q;
    huff_ch_d  = huff_ch_q;
    huff_buf_d = huff_buf_q;
    mac_gr_d   = mac_gr_q;
    mac_ch_d   = mac_ch_q;
    mac_buf_d  = mac_buf_q;

    // Stage 1: the unit descriptor is captured at launch and held until the
    // next launch.
    case (h_state_q)
      H_IDLE: begin
        if (h_launch) begin
          h_state_d  = H_START;
          huff_gr_d  = stereo_q ? h_cnt_q[1] : h_cnt_q[0];
          huff_ch_d  = stereo_q & h_cnt_q[0];
          huff_buf_d = wr_ptr_q;
        end
      end
      H_START:     h_state_d = H_WAIT_BUSY;
      H_WAIT_BUSY: if (!huff_done) h_state_d = H_WAIT_DONE;
      H_WAIT_DONE: if (huff_done)  h_state_d = H_IDLE;
      default:     h_state_d = H_IDLE;
    endcase

    case (m_state_q)
      M_IDLE: begin
        if (m_launch) begin
          m_state_d = M_START;
          mac_gr_d  = stereo_q ? m_cnt_q[1] : m_cnt_q[0];
          mac_ch_d  = stereo_q & m_cnt_q[0];
          mac_buf_d = rd_ptr_q;
        end
      end
      M_START:     m_state_d = M_WAIT_BUSY;
      M_WAIT_BUSY: if (!mac_done) m_state_d = M_WAIT_DONE;
      M_WAIT_DONE: if (mac_done)  m_state_d = M_IDLE;
      default:     m_state_d = M_IDLE;
    endcase

    // A stage-1 fill and a stage-2 drain in the same cycle always touch
    // different halves, so both updates are applied.
    if (h_cmpl) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
      h_cnt_d          = h_cnt_q + 3'd1;
    end
    if (m_cmpl) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
      m_cnt_d          = m_cnt_q + 3'd1;
    end

    case (f_state_q)
      F_IDLE: begin
        if (frame_valid & module_en & ~err_s) begin
          f_state_d = F_RUN;
          stereo_d  = stereo;
          h_cnt_d   = '0;
          m_cnt_d   = '0;
        end
      end
      F_RUN:   if (m_cnt_q == units) f_state_d = F_ACK;
      F_ACK:   f_state_d = F_IDLE;
      default: f_state_d = F_IDLE;
    endcase

    if (wd_abort) begin
      f_state_d = F_IDLE;
      h_state_d = H_IDLE;
      m_state_d = M_IDLE;
      full_d    = '0;
      wr_ptr_d  = 1'b0;
      rd_ptr_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      f_state_q  <= F_IDLE;
      h_state_q  <= H_IDLE;
      m_state_q  <= M_IDLE;
      stereo_q   <= 1'b0;
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      h_cnt_q    <= '0;
      m_cnt_q    <= '0;
      huff_gr_q  <= 1'b0;
      huff_ch_q  <= 1'b0;
      huff_buf_q <= 1'b0;
      mac_gr_q   <= 1'b0;
      mac_ch_q   <= 1'b0;
      mac_buf_q  <= 1'b0;
    end else begin
      f_state_q  <= f_state_d;
      h_state_q  <= h_state_d;
      m_state_q  <= m_state_d;
      stereo_q   <= stereo_d;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      h_cnt_q    <= h_cnt_d;
      m_cnt_q    <= m_cnt_d;
      huff_gr_q  <= huff_gr_d;
      huff_ch_q  <= huff_ch_d;
      huff_buf_q <= huff_buf_d;
      mac_gr_q   <= mac_gr_d;
      mac_ch_q   <= mac_ch_d;
      mac_buf_q  <= mac_buf_d;
    end
  end

`ifdef MP3_SCHED_WDOG_EN
  logic [WDOG_W-1:0] wd_h_q, wd_h_d;
  logic [WDOG_W-1:0] wd_m_q, wd_m_d;
  logic              err_q, err_d;
  logic              h_wait, m_wait;

  assign h_wait   = (h_state_q == H_WAIT_BUSY) | (h_state_q == H_WAIT_DONE);
  assign m_wait   = (m_state_q == M_WAIT_BUSY) | (m_state_q == M_WAIT_DONE);
  // The trip decision uses registered values only. This keeps the abort path
  // out of the next-state loop.
  assign wd_abort = (h_wait & (wd_h_q == '1)) | (m_wait & (wd_m_q == '1));
  assign err_s    = err_q;

  always_comb begin
    wd_h_d = '0;
    wd_m_d = '0;
    err_d  = err_q | wd_abort;
    if (h_wait && (h_state_d == h_state_q)) wd_h_d = wd_h_q + 1'b1;
    if (m_wait && (m_state_d == m_state_q)) wd_m_d = wd_m_q + 1'b1;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wd_h_q <= '0;
      wd_m_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_h_q <= wd_h_d;
      wd_m_q <= wd_m_d;
      err_q  <= err_d;
    end
  end
`else
  assign wd_abort = 1'b0;
  assign err_s    = 1'b0;
`endif

  assign frame_ack  = (f_state_q == F_ACK);
  assign busy       = (f_state_q != F_IDLE);
  assign err        = err_s;
  assign huff_start = (h_state_q == H_START);
  assign huff_gr    = huff_gr_q;
  assign huff_ch    = huff_ch_q;
  assign huff_buf   = huff_buf_q;
  assign mac_start  = (m_state_q == M_START);
  assign mac_gr     = mac_gr_q;
  assign mac_ch     = mac_ch_q;
  assign mac_buf    = mac_buf_q;

endmodule

// File: tb/tb_mp3_stage_sched.sv
// tb_mp3_stage_sched
//   Directed bench for mp3_stage_sched. Table-driven frames are followed by
//   hand-written sequences for pcm stall, module_en gating, a done input that
//   is already low at launch, a mid-frame reset and the optional watchdog.
//   A combined monitor and stage responder runs 1 ns after each rising edge.
module tb_mp3_stage_sched;
`ifdef MP3_SCHED_WDOG_EN
  localparam int unsigned TB_WDOG_W = 8;
`else
  localparam int unsigned TB_WDOG_W = 20;
`endif
  localparam int LOGN = 64;

  logic CLK_I = 1'b0;
  logic RST_I, module_en, frame_valid, stereo, pcm_free;
  logic huff_done, mac_done;
  logic frame_ack, huff_start, huff_gr, huff_ch, huff_buf;
  logic mac_start, mac_gr, mac_ch, mac_buf, busy, err;

  always #5 CLK_I = ~CLK_I;

  mp3_stage_sched #(.WDOG_W(TB_WDOG_W)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .module_en(module_en),
    .frame_valid(frame_valid), .stereo(stereo), .frame_ack(frame_ack),
    .huff_start(huff_start), .huff_done(huff_done), .huff_gr(huff_gr),
    .huff_ch(huff_ch), .huff_buf(huff_buf), .mac_start(mac_start),
    .mac_done(mac_done), .mac_gr(mac_gr), .mac_ch(mac_ch), .mac_buf(mac_buf),
    .pcm_free(pcm_free), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int minv);
    n_checks++;
    if (act < minv) begin
      n_errors++;
      $display("FAIL %s: got %0d, required >= %0d", name, act, minv);
    end
  endtask

  // Monitor logs and responder state. The main process only reads these.
  int cyc = 0;
  int nh = 0, nm = 0, nack = 0, nhc = 0, hold_err = 0;
  logic [2:0] h_log [LOGN];
  logic [2:0] m_log [LOGN];
  int h_cyc [LOGN];
  int h_cmp [LOGN];
  int m_cyc [LOGN];
  int h_lat = 10, m_lat = 10;
  bit h_hold = 0, m_hold = 0;

  initial begin
    int  h_tmr, m_tmr;
    bit  h_pend, m_pend, h_act, m_act, nd;
    logic [2:0] h_cur, m_cur;
    h_tmr = 0; m_tmr = 0; h_pend = 0; m_pend = 0; h_act = 0; m_act = 0;
    h_cur = '0; m_cur = '0;
    huff_done = 1'b1;
    mac_done  = 1'b1;
    forever begin
      @(posedge CLK_I);
      #1;
      cyc++;
      if (RST_I) begin
        h_tmr = 0; m_tmr = 0; h_pend = 0; m_pend = 0; h_act = 0; m_act = 0;
        huff_done = !h_hold;
        mac_done  = !m_hold;
      end else begin
        if (h_act && ({huff_gr, huff_ch, huff_buf} != h_cur)) hold_err++;
        if (m_act && ({mac_gr, mac_ch, mac_buf} != m_cur)) hold_err++;
        if (frame_ack) nack++;
        // Stage model: done drops one cycle after start and rises lat cycles later.
        if (h_pend) begin h_tmr = h_lat; h_pend = 0; end
        else if (h_tmr > 0) h_tmr--;
        if (huff_start) begin
          if (nh < LOGN) begin h_log[nh] = {huff_gr, huff_ch, huff_buf}; h_cyc[nh] = cyc; end
          nh++;
          h_cur = {huff_gr, huff_ch, huff_buf};
          h_act = 1; h_pend = 1;
        end
        nd = !h_hold && (h_tmr == 0);
        if (h_act && !h_pend && nd && !huff_done) begin
          if (nhc < LOGN) h_cmp[nhc] = cyc;
          nhc++;
          h_act = 0;
        end
        huff_done = nd;

        if (m_pend) begin m_tmr = m_lat; m_pend = 0; end
        else if (m_tmr > 0) m_tmr--;
        if (mac_start) begin
          if (nm < LOGN) begin m_log[nm] = {mac_gr, mac_ch, mac_buf}; m_cyc[nm] = cyc; end
          nm++;
          m_cur = {mac_gr, mac_ch, mac_buf};
          m_act = 1; m_pend = 1;
        end
        nd = !m_hold && (m_tmr == 0);
        if (m_act && !m_pend && nd && !mac_done) m_act = 0;
        mac_done = nd;
      end
    end
  end

  function automatic int hl(input int idx);
    return (idx >= 0 && idx < LOGN) ? int'(h_log[idx]) : -1;
  endfunction
  function automatic int ml(input int idx);
    return (idx >= 0 && idx < LOGN) ? int'(m_log[idx]) : -1;
  endfunction
  function automatic int all_outs();
    return int'({frame_ack, huff_start, huff_gr, huff_ch, huff_buf,
                 mac_start, mac_gr, mac_ch, mac_buf, busy, err});
  endfunction

  task automatic run_frame(input logic s, output int c0);
    @(negedge CLK_I);
    stereo = s;
    frame_valid = 1'b1;
    c0 = cyc;
    @(negedge CLK_I);
    frame_valid = 1'b0;
    stereo = ~s;
  endtask

  task automatic wait_ack(input string name, input int ack0, input int limit);
    int n;
    n = 0;
    while (nack == ack0 && n < limit) begin
      @(negedge CLK_I);
      n++;
    end
    check({name, "_ack_seen"}, (nack > ack0) ? 1 : 0, 1);
    @(negedge CLK_I);
    @(negedge CLK_I);
  endtask

  typedef struct {
    logic       stereo;
    int         lat_h;
    int         lat_m;
    int         units;
    logic [7:0] gc;    // {gr,ch} of unit i at [2i+:2]
    logic [3:0] bufs;  // ping-pong half of unit i at [i]
  } vec_t;

  initial begin
    vec_t vecs [4];
    vec_t v;
    logic [7:0] gc;
    logic [3:0] bf;
    int c0, hb, mb, ab, cb, h0, n;
    string nm_s;

    vecs[0] = '{1'b1, 10, 10, 4, 8'b11_10_01_00, 4'b1010};
    vecs[1] = '{1'b0, 10, 10, 2, 8'b00_00_10_00, 4'b0010};
    vecs[2] = '{1'b1,  3, 20, 4, 8'b11_10_01_00, 4'b1010};
    vecs[3] = '{1'b1, 15,  2, 4, 8'b11_10_01_00, 4'b1010};

    RST_I = 1'b1; module_en = 1'b1; frame_valid = 1'b0; stereo = 1'b0; pcm_free = 1'b1;
    repeat (3) @(negedge CLK_I);
    check("reset_outputs", all_outs(), 0);
    RST_I = 1'b0;
    @(negedge CLK_I);

    for (int k = 0; k < 4; k++) begin
      v = vecs[k];
      gc = v.gc;
      bf = v.bufs;
      h_lat = v.lat_h;
      m_lat = v.lat_m;
      hb = nh; mb = nm; ab = nack; cb = nhc; h0 = hold_err;
      run_frame(v.stereo, c0);
      nm_s = $sformatf("v%0d", k);
      wait_ack(nm_s, ab, 3000);
      check({nm_s, "_start_latency"}, (hb < LOGN) ? h_cyc[hb] : -1, c0 + 2);
      check({nm_s, "_huff_count"}, nh - hb, v.units);
      check({nm_s, "_mac_count"}, nm - mb, v.units);
      check({nm_s, "_ack_count"}, nack - ab, 1);
      check({nm_s, "_busy_after"}, int'(busy), 0);
      check({nm_s, "_hold"}, hold_err - h0, 0);
      for (int i = 0; i < v.units; i++) begin
        check($sformatf("%s_huff%0d_gr_ch_buf", nm_s, i), hl(hb + i), int'({gc[2*i+:2], bf[i]}));
        check($sformatf("%s_mac%0d_gr_ch_buf", nm_s, i), ml(mb + i), int'({gc[2*i+:2], bf[i]}));
        if (mb + i < LOGN && cb + i < LOGN)
          check_ge($sformatf("%s_mac%0d_after_cmpl", nm_s, i), m_cyc[mb + i], h_cmp[cb + i] + 2);
      end
    end

    // pcm_free low: two units fill both halves, then stage 1 stalls.
    h_lat = 10; m_lat = 10;
    hb = nh; mb = nm; ab = nack;
    pcm_free = 1'b0;
    run_frame(1'b1, c0);
    repeat (500) @(negedge CLK_I);
    check("pcm_stall_huff_count", nh - hb, 2);
    check("pcm_stall_mac_count", nm - mb, 0);
    check("pcm_stall_busy", int'(busy), 1);
    check("pcm_stall_no_ack", nack - ab, 0);
    pcm_free = 1'b1;
    wait_ack("pcm", ab, 3000);
    check("pcm_resume_huff_count", nh - hb, 4);
    check("pcm_resume_mac_count", nm - mb, 4);
    check("pcm_last_mac", ml(mb + 3), 7);

    // module_en gating: no accept while low; in-flight unit finishes; resume.
    hb = nh; mb = nm; ab = nack;
    module_en = 1'b0;
    @(negedge CLK_I);
    stereo = 1'b1;
    frame_valid = 1'b1;
    repeat (5) @(negedge CLK_I);
    check("en_low_not_accepted", int'(busy), 0);
    module_en = 1'b1;
    c0 = cyc;
    @(negedge CLK_I);
    frame_valid = 1'b0;
    n = 0;
    while (nh == hb && n < 50) begin @(negedge CLK_I); n++; end
    module_en = 1'b0;
    check("en_start_latency", (hb < LOGN) ? h_cyc[hb] : -1, c0 + 2);
    repeat (100) @(negedge CLK_I);
    check("en_off_huff_count", nh - hb, 1);
    check("en_off_mac_count", nm - mb, 0);
    check("en_off_busy", int'(busy), 1);
    module_en = 1'b1;
    wait_ack("en", ab, 3000);
    check("en_resume_huff_count", nh - hb, 4);
    check("en_resume_mac_count", nm - mb, 4);

    // huff_done already low at launch: must wait, no second launch.
    hb = nh; mb = nm; ab = nack;
    h_hold = 1;
    repeat (2) @(negedge CLK_I);
    run_frame(1'b0, c0);
    repeat (30) @(negedge CLK_I);
    check("done_low_single_launch", nh - hb, 1);
    check("done_low_busy", int'(busy), 1);
    h_hold = 0;
    wait_ack("done_low", ab, 3000);
    check("done_low_huff_count", nh - hb, 2);
    check("done_low_mac_count", nm - mb, 2);
    check("done_low_unit1", hl(hb + 1), 5);

    // Reset during the third unit, then a clean restart.
    hb = nh; ab = nack;
    run_frame(1'b1, c0);
    n = 0;
    while (nh - hb < 3 && n < 500) begin @(negedge CLK_I); n++; end
    check("rst_reached_unit3", nh - hb, 3);
    RST_I = 1'b1;
    #1;
    check("rst_async_outputs", all_outs(), 0);
    @(negedge CLK_I);
    check("rst_next_cycle_outputs", all_outs(), 0);
    check("rst_no_ack", nack - ab, 0);
    RST_I = 1'b0;
    @(negedge CLK_I);
    hb = nh; mb = nm; ab = nack;
    run_frame(1'b1, c0);
    wait_ack("rst_restart", ab, 3000);
    check("rst_restart_first", hl(hb), 0);
    check("rst_restart_huff_count", nh - hb, 4);
    check("rst_restart_mac_count", nm - mb, 4);

`ifdef MP3_SCHED_WDOG_EN
    h_hold = 1;
    repeat (2) @(negedge CLK_I);
    run_frame(1'b0, c0);
    repeat (50) @(negedge CLK_I);
    check("wdog_err_not_early", int'(err), 0);
    n = 0;
    while (!err && n < 600) begin @(negedge CLK_I); n++; end
    check("wdog_err_set", int'(err), 1);
    check("wdog_busy_cleared", int'(busy), 0);
    h_hold = 0;
    @(negedge CLK_I);
    hb = nh;
    frame_valid = 1'b1;
    repeat (10) @(negedge CLK_I);
    frame_valid = 1'b0;
    check("wdog_frame_ignored", int'(busy), 0);
    check("wdog_no_launch", nh - hb, 0);
    check("wdog_err_sticky", int'(err), 1);
`else
    check("err_tied_low", int'(err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got time %0t, required completion earlier", $time);
    $fatal(1, "global timeout");
  end
endmodule
